countdown_scheduler: RTL

Shares a single down-counting timer among `N_REQ` requesters. The block arbitrates pending requests round-robin and loads the winner's limit into its internal countdown register. It then decrements the register to zero and pulses that requester's `done`. It sits between the per-channel control logic and the timing datapath, replacing per-channel free-running down-counters with one sequenced resource.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/countdown_scheduler_arbiter.sv | 34 +++
 rtl/countdown_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared constants for countdown_scheduler: FSM state encoding, default
// geometry and the modulo-increment helper used for the round-robin pointer.
package countdown_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 7;
  localparam int DEF_PRESCALE = 50;

  // Next requester index after v, wrapping at n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/countdown_scheduler_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or
// after ptr, wrapping modulo N_REQ; returns one-hot gnt and binary idx.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);

  logic          found_s;
  logic [PW-1:0] cand_s;

  // Scan from ptr upward; the first request hit wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = PW'((int'(ptr) + i) % N_REQ);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: one shared down-counter granted round-robin to N_REQ
// requesters. Optional prescaler enabled by COUNTDOWN_SCHED_PRESCALE_EN.
module countdown_scheduler
  import countdown_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   limit,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  localparam int PW = $clog2(N_REQ);

  logic [1:0]       state_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    owner_r;
  logic [WIDTH-1:0] count_r;
  logic [N_REQ-1:0] grant_r;
  logic [N_REQ-1:0] done_r;
  logic             busy_r;
  logic [N_REQ-1:0] arb_gnt_s;
  logic [PW-1:0]    arb_idx_s;
  logic             step_s;
  logic [WIDTH-1:0] lim_s [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lim
    assign lim_s[gi] = limit[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

`ifdef COUNTDOWN_SCHED_PRESCALE_EN
  localparam int PSW = $clog2(PRESCALE);
  logic [PSW-1:0] pre_r;

  // Prescaler restarts whenever the counter is idle, so each grant sees a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r <= '0;
    end else if (state_r != ST_RUN) begin
      pre_r <= '0;
    end else if (pre_r == PSW'(PRESCALE - 1)) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PSW'(1);
    end
  end

  assign step_s = (pre_r == PSW'(PRESCALE - 1));
`else
  assign step_s = 1'b1;
`endif

  // Scheduler FSM; abort takes priority over the zero check in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      count_r <= '0;
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            owner_r <= arb_idx_s;
            count_r <= lim_s[arb_idx_s];
            grant_r <= arb_gnt_s;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!req[owner_r]) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            ptr_r   <= PW'(wrap_inc(int'(owner_r), N_REQ));
            state_r <= ST_IDLE;
          end else if (count_r == '0) begin
            done_r  <= grant_r;
            state_r <= ST_DONE;
          end else if (step_s) begin
            count_r <= count_r - WIDTH'(1);
          end else begin
            count_r <= count_r;
          end
        end
        ST_DONE: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          ptr_r   <= PW'(wrap_inc(int'(owner_r), N_REQ));
          state_r <= ST_IDLE;
        end
        default: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant = grant_r;
  assign done  = done_r;
  assign busy  = busy_r;
  assign count = count_r;

endmodule
